// File: rtl/pri_event_queue.sv
// pri_event_queue: collects single-cycle event pulses from 16 sources into a
// sticky pending register and offers them one at a time, highest index
// first, over a valid/ready handshake. Collisions on an already-pending
// source are tallied in a saturating lost counter.
//
// state | meaning
// IDLE  | no offer outstanding; picks the highest pending bit if any
// OFFER | out_idx offered; held until the consumer accepts
module pri_event_queue #(
    parameter int LOST_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       req,
    output logic              out_valid,
    output logic [3:0]        out_idx,
    input  logic              out_ready,
    output logic [15:0]       pending,
    output logic [LOST_W-1:0] lost
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [LOST_W-1:0] LOST_MAX = '1;

    state_t              state_q, state_d;
    logic [15:0]         pending_q, pending_d;
    logic [3:0]          idx_q, idx_d;
    logic [LOST_W-1:0]   lost_q, lost_d;
    logic [3:0]          top_idx;
    logic [15:0]         clr;
    logic                accept;
    logic                collide;

    // Highest set bit of the registered pending vector (bit 15 wins).
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (pending_q[i]) begin
                top_idx = 4'(i);
            end
        end
    end

    // Pending update and lost-event tally; a new request wins over a same-cycle clear.
    always_comb begin
        accept    = (state_q == OFFER) && out_ready;
        clr       = accept ? (16'd1 << idx_q) : 16'd0;
        pending_d = (pending_q & ~clr) | req;
        collide   = |(req & pending_q & ~clr);
        lost_d    = (collide && (lost_q != LOST_MAX)) ? lost_q + 1'b1 : lost_q;
    end

    // Offer FSM next state; the selected index is frozen for the whole offer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    idx_d   = top_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; requests in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            lost_q    <= lost_d;
        end
    end

    assign out_valid = (state_q == OFFER);
    assign out_idx   = idx_q;
    assign pending   = pending_q;
    assign lost      = lost_q;

endmodule

// File: tb/tb_pri_event_queue.sv
// Bench for pri_event_queue: directed scenarios followed by random traffic,
// checked against a behavioural model with an offer scoreboard.
module tb_pri_event_queue;

    localparam int LOST_W   = 8;
    localparam int LOST_MAX = (1 << LOST_W) - 1;

    logic              clk;
    logic              rst;
    logic [15:0]       req;
    logic              out_valid;
    logic [3:0]        out_idx;
    logic              out_ready;
    logic [15:0]       pending;
    logic [LOST_W-1:0] lost;

    pri_event_queue #(.LOST_W(LOST_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .lost      (lost)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit [15:0] m_pend  = '0;
    bit        m_offer = 1'b0;
    int        m_idx   = 0;
    int        m_lost  = 0;
    int        exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int highest(input bit [15:0] v);
        int h = -1;
        for (int i = 15; i >= 0; i--) begin
            if (v[i] && h < 0) h = i;
        end
        return h;
    endfunction

    // Model: evaluated from the inputs seen at each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pend  = '0;
                m_offer = 1'b0;
                m_idx   = 0;
                m_lost  = 0;
            end else begin
                bit        acc;
                bit        hit;
                bit [15:0] nxt;
                acc = m_offer && out_ready;
                hit = 1'b0;
                for (int i = 0; i < 16; i++) begin
                    if (req[i] && m_pend[i] && !(acc && i == m_idx)) hit = 1'b1;
                end
                if (hit && m_lost < LOST_MAX) m_lost++;
                nxt = m_pend;
                if (acc) nxt[m_idx] = 1'b0;
                nxt = nxt | req;
                if (!m_offer && m_pend != 0) begin
                    m_idx   = highest(m_pend);
                    m_offer = 1'b1;
                    exp_q.push_back(m_idx);
                end else if (acc) begin
                    m_offer = 1'b0;
                end
                m_pend = nxt;
            end
        end
    end

    // Monitor: pops the scoreboard on every new offer, checks status each cycle.
    initial begin
        bit prev_v = 1'b0;
        int cur    = 0;
        forever begin
            @(negedge clk);
            chk("out_valid", int'(out_valid), int'(m_offer));
            chk("pending", int'(pending), int'(m_pend));
            chk("lost", int'(lost), m_lost);
            if (out_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL offer_unexpected: got idx %0d expected no offer at %0t", out_idx, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("offer_idx", int'(out_idx), e);
                    cur = int'(out_idx);
                end
            end else if (out_valid && prev_v) begin
                chk("idx_stable", int'(out_idx), cur);
            end
            prev_v = out_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input logic [15:0] r, input logic rd);
        req       = r;
        out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;

        // Reset then idle
        cyc(16'h0000, 1'b0);
        cyc(16'h0000, 1'b0);
        rst = 1'b0;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_lost", int'(lost), 0);
        for (int i = 0; i < 20; i++) cyc(16'h0000, 1'b1);

        // Single event: offer appears two edges after the pulse, for one cycle
        cyc(16'h0020, 1'b1);
        chk("single_pend", int'(pending), 16'h0020);
        chk("single_notyet", int'(out_valid), 0);
        cyc(16'h0000, 1'b1);
        chk("single_valid", int'(out_valid), 1);
        chk("single_idx", int'(out_idx), 5);
        cyc(16'h0000, 1'b1);
        chk("single_drop", int'(out_valid), 0);
        chk("single_clear", int'(pending), 0);

        // Simultaneous events drained in priority order
        cyc(16'h8421, 1'b1);
        for (int i = 0; i < 10; i++) cyc(16'h0000, 1'b1);
        chk("multi_clear", int'(pending), 0);

        // Backpressure and no pre-emption
        cyc(16'h0002, 1'b0);
        cyc(16'h0000, 1'b0);
        cyc(16'h4000, 1'b0);
        for (int i = 0; i < 4; i++) cyc(16'h0000, 1'b0);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_idx", int'(out_idx), 1);
        cyc(16'h0000, 1'b1);
        cyc(16'h0000, 1'b0);
        chk("bp_next_idx", int'(out_idx), 14);
        cyc(16'h0000, 1'b1);
        cyc(16'h0000, 1'b0);
        chk("bp_lost", int'(lost), 0);

        // Same-cycle accept and re-request of the offered source
        cyc(16'h0008, 1'b0);
        cyc(16'h0000, 1'b0);
        cyc(16'h0008, 1'b1);
        chk("sc_pend", int'(pending), 16'h0008);
        chk("sc_lost", int'(lost), 0);
        cyc(16'h0000, 1'b0);
        chk("sc_reoffer", int'(out_valid), 1);
        chk("sc_reidx", int'(out_idx), 3);
        cyc(16'h0000, 1'b1);
        cyc(16'h0000, 1'b1);

        // Random traffic with occasional reset
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc(16'($urandom & $urandom & $urandom), 1'($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) cyc(16'h0000, 1'b1);

        // Collision saturation
        rst = 1'b1;
        cyc(16'h0000, 1'b0);
        rst = 1'b0;
        cyc(16'h0008, 1'b0);
        for (int i = 0; i < 300; i++) cyc(16'h0008, 1'b0);
        chk("sat_lost", int'(lost), LOST_MAX);
        chk("sat_idx", int'(out_idx), 3);
        cyc(16'h0008, 1'b1);
        chk("sat_keep", int'(pending), 16'h0008);
        chk("sat_lost_hold", int'(lost), LOST_MAX);
        cyc(16'h0000, 1'b0);
        cyc(16'h0000, 1'b1);
        cyc(16'h0000, 1'b1);

        // Reset mid-offer
        cyc(16'h00F0, 1'b0);
        cyc(16'h0000, 1'b0);
        chk("mid_valid", int'(out_valid), 1);
        chk("mid_idx", int'(out_idx), 7);
        rst = 1'b1;
        cyc(16'h0000, 1'b0);
        rst = 1'b0;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_pend", int'(pending), 0);
        chk("mid_rst_lost", int'(lost), 0);
        cyc(16'h0001, 1'b1);
        cyc(16'h0000, 1'b1);
        chk("mid_after_valid", int'(out_valid), 1);
        chk("mid_after_idx", int'(out_idx), 0);
        for (int i = 0; i < 5; i++) cyc(16'h0000, 1'b1);

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pri_event_queue.md
Name: pri_event_queue

Overview:
- Collects single-cycle event pulses from 16 sources into a sticky pending register.
- Presents pending events one at a time, highest index first, as a 4-bit source index with a valid/ready handshake.
- Sits directly upstream of pri_en16-style priority selection and downstream of per-channel event strobes (e.g. packet-arrival flags).
- Serialises simultaneous events toward a single consumer such as a register-file servicer or a mailbox writer.

Parameters:
- LOST_W, 8, width of the saturating lost-event counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  16  event pulses; req[i]=1 for one cycle marks source i pending
- out_valid  output  1  an index is being offered
- out_idx  output  4  index of the offered source; highest set pending bit at selection time
- out_ready  input  1  consumer accepts the offered index when out_valid=1
- pending  output  16  current pending register, for status readback
- lost  output  LOST_W  count of events dropped because the source was already pending

Behaviour:
- Reset (rst=1 at a clock edge) clears all state:
  - pending=0, out_valid=0, out_idx=0, lost=0, FSM=IDLE.
  - req pulses in a reset cycle are ignored.
  - Reset asserted while an offer is outstanding drops the offer with no accept recorded.
- Pending update, every non-reset cycle: pending_next = (pending & ~clr) | req.
  - clr is one-hot bit out_idx when an accept occurs this cycle, else 0.
  - Set wins over clear: if req[out_idx]=1 in the accept cycle, that bit stays set and will be offered again later.
- Lost counter:
  - Increments by 1 for each cycle in which any bit has req[i]=1 and pending[i]=1, unless that bit is being cleared by an accept in the same cycle.
  - At most +1 per cycle, even if several sources collide.
  - Saturates at 2^LOST_W-1 and never wraps.
- FSM has two states.
  - IDLE:
    - out_valid=0; out_idx holds its last value.
    - If registered pending!=0, load out_idx with the highest set bit of pending and go to OFFER.
    - Selection uses the registered pending, not pending_next.
  - OFFER:
    - out_valid=1; out_idx is stable for the whole offer.
    - Accept = out_valid & out_ready. On accept, clear pending[out_idx] per the rule above and go to IDLE.
    - Without out_ready, stay in OFFER indefinitely. A higher-priority req arriving during the offer does not pre-empt it.
- Latency:
  - req[i] at edge N gives pending[i]=1 after edge N.
  - out_valid=1 with out_idx=i after edge N+1, if FSM was IDLE and i is the highest set bit.
- Throughput: with out_ready held high, at most one index every 2 cycles (OFFER, IDLE, OFFER, ...).
- out_ready while out_valid=0 has no effect.
- Priority matches pri_en16 ordering: bit 15 highest, bit 0 lowest.
- No combinational path from req or out_ready to out_valid or out_idx.

Test Plan:
- Reset then idle: assert rst for 2 cycles, req=0 -> out_valid=0, pending=0, lost=0 for 20 cycles.
- Single event: req=16'h0020 for 1 cycle, out_ready=1 -> out_valid rises 2 edges later with out_idx=5 for exactly 1 cycle; pending returns to 0; lost=0.
- Simultaneous events, ready=1: req=16'h8421 for 1 cycle -> offers in order 15, 10, 5, 0, each out_valid pulse separated by one idle cycle; pending ends at 0.
- Backpressure and no pre-emption:
  - req=16'h0002 is offered with out_ready=0; then req=16'h4000 -> out_idx stays 1 until out_ready=1.
  - After accept, next offer is out_idx=14.
  - lost=0.
- Collision and saturation:
  - With out_ready=0, pulse req[3] 300 times while pending[3]=1 -> lost saturates at 255.
  - Same-cycle accept of idx 3 with req[3]=1 -> bit 3 stays pending, lost unchanged, idx 3 re-offered.
- Reset mid-offer: assert rst while out_valid=1 with pending=16'h00F0 -> next cycle out_valid=0, pending=0, lost=0; a subsequent req=16'h0001 yields out_idx=0 after 2 edges.
